// File: rtl/ifetch_pkg.sv
// ifetch_pkg: shared types and constants for the instruction fetch queue.
package ifetch_pkg;

    localparam logic [31:0] IFETCH_NOP = 32'h0000_0013;

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] inst;
        logic        err;
    } ifetch_entry_t;

endpackage

// File: rtl/ifetch_fifo.sv
// ifetch_fifo: DEPTH-entry register FIFO of fetched instructions with flush.
module ifetch_fifo
    import ifetch_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     rstn,
    input  logic                     push,
    input  logic                     pop,
    input  logic                     flush,
    input  ifetch_entry_t            din,
    output ifetch_entry_t            dout,
    output logic [$clog2(DEPTH):0]   count
);

    localparam int AW = $clog2(DEPTH);

    ifetch_entry_t  mem [DEPTH];
    logic [AW-1:0]  rd_ptr;
    logic [AW-1:0]  wr_ptr;

    always_ff @(posedge clk) begin
        if (!rstn || flush) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
        end else begin
            rd_ptr <= rd_ptr + AW'(pop);
            wr_ptr <= wr_ptr + AW'(push);
            count  <= count + (AW+1)'(push) - (AW+1)'(pop);
        end
    end

    // Storage is not reset; the caller never pushes during flush or reset.
    always_ff @(posedge clk) begin
        if (push)
            mem[wr_ptr] <= din;
    end

    assign dout = mem[rd_ptr];

endmodule

// File: rtl/inst_fetch_queue.sv
// inst_fetch_queue: fetch PC owner feeding a decode FIFO from a combinational ROM.
// IFETCH_MISALIGN_CHK_EN: misaligned redirect/reset PC queues one faulting entry and halts.
module inst_fetch_queue
    import ifetch_pkg::*;
#(
    parameter int          DEPTH      = 4,
    parameter logic [31:0] RESET_PC   = 32'h0000_0000,
    parameter int          IROM_SPACE = 1024
) (
    input  logic        clk,
    input  logic        rstn,
    input  logic        fetch_en,
    input  logic        redirect_valid,
    input  logic [31:0] redirect_pc,
    output logic [31:0] inst_addr,
    input  logic [31:0] inst_i,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [31:0] out_inst,
    output logic [31:0] out_pc,
    output logic        out_err
);

    localparam int CW = $clog2(DEPTH) + 1;
    localparam logic [CW-1:0] FULL = CW'(DEPTH);

    logic [31:0]   fetch_pc;
    logic [31:0]   load_pc;
    logic [CW-1:0] count;
    logic          pop;
    logic          space;
    logic          in_range;
    logic          push;
    logic          push_norm;
    logic          push_fault;
    ifetch_entry_t din;
    ifetch_entry_t head;

    assign pop      = out_valid & out_ready;
    assign space    = (count < FULL) | pop;
    // 33-bit compare so PCs near 2^32 cannot wrap back into range.
    assign in_range = ({1'b0, fetch_pc} + 33'd3) < 33'(IROM_SPACE);

`ifdef IFETCH_MISALIGN_CHK_EN
    localparam logic [31:0] RST_PC = RESET_PC;
    logic halted;
    logic fault_pend;
    assign load_pc    = redirect_pc;
    assign push_fault = fetch_en & ~redirect_valid & fault_pend & space;
    assign push_norm  = fetch_en & ~redirect_valid & ~halted & ~fault_pend & space;
    always_ff @(posedge clk) begin
        if (!rstn) begin
            fault_pend <= RESET_PC[1:0] != 2'b00;
            halted     <= RESET_PC[1:0] != 2'b00;
        end else if (redirect_valid) begin
            fault_pend <= redirect_pc[1:0] != 2'b00;
            halted     <= redirect_pc[1:0] != 2'b00;
        end else if (push_fault) begin
            fault_pend <= 1'b0;
        end
    end
`else
    localparam logic [31:0] RST_PC = {RESET_PC[31:2], 2'b00};
    assign load_pc    = redirect_pc & 32'hFFFF_FFFC;
    assign push_fault = 1'b0;
    assign push_norm  = fetch_en & ~redirect_valid & space;
`endif

    assign push = push_norm | push_fault;
    assign din  = '{pc: fetch_pc, inst: (push_fault | ~in_range) ? IFETCH_NOP : inst_i, err: push_fault};

    always_ff @(posedge clk) begin
        if (!rstn)
            fetch_pc <= RST_PC;
        else if (redirect_valid)
            fetch_pc <= load_pc;
        else if (push_norm)
            fetch_pc <= fetch_pc + 32'd4;
    end

    ifetch_fifo #(.DEPTH(DEPTH)) u_fifo (
        .clk   (clk),
        .rstn  (rstn),
        .push  (push),
        .pop   (pop),
        .flush (redirect_valid),
        .din   (din),
        .dout  (head),
        .count (count)
    );

    assign inst_addr = fetch_pc;
    assign out_valid = count != '0;
    assign out_inst  = head.inst;
    assign out_pc    = head.pc;
    assign out_err   = out_valid & head.err;

endmodule
